// File: rtl/addsub_server_pkg.sv
// addsub_server_pkg: FSM state encoding and operation mode constants shared by the add/sub server.
package addsub_server_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_e;
  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;
endpackage

// File: rtl/addsub_server_rr_arbiter.sv
// rr_arbiter: combinational round-robin selector, first request at or after ptr_i (wrapping) wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid_o && req_i[(int'(ptr_i) + i) % N]) begin
        valid_o = 1'b1;
        idx_o = IW'((int'(ptr_i) + i) % N);
        gnt_o[(int'(ptr_i) + i) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/addsub_server.sv
// addsub_server: shared add/subtract unit serving PORTS requesters round-robin, one op every 3 cycles.
module addsub_server
  import addsub_server_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PORTS = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [PORTS-1:0]       req_i,
  input  logic [PORTS-1:0]       mode_i,
  input  logic [PORTS*WIDTH-1:0] a_i,
  input  logic [PORTS*WIDTH-1:0] b_i,
  output logic [PORTS-1:0]       ready_o,
  output logic [WIDTH-1:0]       res_o,
  output logic                   carry_o,
  output logic                   busy_o
);
  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
  state_e           state_q;
  logic [IW-1:0]    rr_ptr_q, port_q;
  logic [PORTS-1:0] gnt_q, ready_q;
  logic             mode_q, carry_q, busy_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [PORTS-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_valid;
  logic [WIDTH:0]   sum_d;
  rr_arbiter #(.N(PORTS), .IW(IW)) u_arb (
    .req_i  (req_i),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .valid_o(gnt_valid)
  );
  // Extra top bit gives carry on add and borrow (a < b) on subtract.
  assign sum_d = (mode_q == MODE_ADD) ? {1'b0, a_q} + {1'b0, b_q} : {1'b0, a_q} - {1'b0, b_q};
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      port_q   <= '0;
      gnt_q    <= '0;
      ready_q  <= '0;
      mode_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (gnt_valid) begin
          port_q  <= gnt_idx;
          gnt_q   <= gnt;
          mode_q  <= mode_i[gnt_idx];
          a_q     <= a_i[gnt_idx*WIDTH +: WIDTH];
          b_q     <= b_i[gnt_idx*WIDTH +: WIDTH];
          busy_q  <= 1'b1;
          state_q <= CALC;
        end
        CALC: begin
          res_q   <= sum_d[WIDTH-1:0];
          carry_q <= sum_d[WIDTH];
          ready_q <= gnt_q;
          state_q <= RESP;
        end
        RESP: begin
          ready_q  <= '0;
          busy_q   <= 1'b0;
          rr_ptr_q <= IW'((int'(port_q) + 1) % PORTS);
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ready_o = ready_q;
  assign res_o   = res_q;
  assign carry_o = carry_q;
  assign busy_o  = busy_q;
endmodule

// File: tb/tb_addsub_server.sv
// tb_addsub_server: directed vectors with a scoreboard queue drained by a negedge monitor.
module tb_addsub_server;
  typedef struct packed {
    logic [3:0] rdy;
    logic [7:0] res;
    logic       c;
  } exp_t;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [3:0]  req_i = '0;
  logic [3:0]  mode_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [3:0]  ready_o;
  logic [7:0]  res_o;
  logic        carry_o;
  logic        busy_o;
  exp_t        sb[$];
  int          rdy_t[$];
  int          n_chk = 0;
  int          n_fail = 0;
  addsub_server #(.WIDTH(8), .PORTS(4)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (req_i),
    .mode_i (mode_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .ready_o(ready_o),
    .res_o  (res_o),
    .carry_o(carry_o),
    .busy_o (busy_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  always @(negedge clk_i) begin
    if (rst_i && ready_o != 4'b0) begin
      chk("ready_onehot", 32'($onehot(ready_o)), 32'd1);
      if (sb.size() == 0) chk("spurious_ready", 32'(ready_o), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("ready", 32'(ready_o), 32'(e.rdy));
        chk("res", 32'(res_o), 32'(e.res));
        chk("carry", 32'(carry_o), 32'(e.c));
      end
    end
  end
  task automatic set_port(input int p, input logic m, input logic [7:0] a, input logic [7:0] b);
    mode_i[p] = m;
    a_i[p*8 +: 8] = a;
    b_i[p*8 +: 8] = b;
  endtask
  task automatic push(input int p, input logic [7:0] res, input logic c);
    exp_t e;
    e.rdy = 4'(1 << p);
    e.res = res;
    e.c = c;
    sb.push_back(e);
  endtask
  task automatic run(input int budget, input bit drop);
    int cyc = 0;
    logic [3:0] r;
    rdy_t.delete();
    while (sb.size() != 0 && cyc < budget) begin
      @(negedge clk_i);
      cyc++;
      r = ready_o;
      if (r != 4'b0) rdy_t.push_back(cyc);
      @(posedge clk_i);
      #1;
      if (drop) req_i &= ~r;
    end
    if (sb.size() != 0) begin
      chk("timeout_pending", sb.size(), 0);
      sb.delete();
    end
  endtask
  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(ready_o), 0);
    chk("rst_res", 32'(res_o), 0);
    chk("rst_carry", 32'(carry_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    // 200 + 100 on port 1
    set_port(1, 1'b1, 8'd200, 8'd100);
    push(1, 8'd44, 1'b1);
    req_i = 4'b0010;
    run(20, 1);
    chk("latency", rdy_t.size() > 0 ? rdy_t[0] : -1, 3);
    chk("busy_after", 32'(busy_o), 0);
    // port 2 subtract with and without borrow
    set_port(2, 1'b0, 8'd5, 8'd9);
    push(2, 8'd252, 1'b1);
    req_i = 4'b0100;
    run(20, 1);
    set_port(2, 1'b0, 8'd9, 8'd5);
    push(2, 8'd4, 1'b0);
    req_i = 4'b0100;
    run(20, 1);
    // pointer now at 3: port 3 beats port 0
    set_port(0, 1'b0, 8'd100, 8'd1);
    set_port(3, 1'b1, 8'd255, 8'd1);
    push(3, 8'd0, 1'b1);
    push(0, 8'd99, 1'b0);
    req_i = 4'b1001;
    run(30, 1);
    // all four held from reset
    rst_i = 1'b0;
    set_port(0, 1'b1, 8'd1, 8'd2);
    set_port(1, 1'b0, 8'd0, 8'd1);
    set_port(2, 1'b1, 8'd128, 8'd128);
    set_port(3, 1'b0, 8'd50, 8'd20);
    req_i = 4'b1111;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    push(0, 8'd3, 1'b0);
    push(1, 8'd255, 1'b1);
    push(2, 8'd0, 1'b1);
    push(3, 8'd30, 1'b0);
    push(0, 8'd3, 1'b0);
    run(40, 0);
    req_i = 4'b0;
    for (int i = 1; i < rdy_t.size(); i++) chk("spacing", rdy_t[i] - rdy_t[i-1], 3);
    chk("ready_count", rdy_t.size(), 5);
    // operands changed and request dropped during CALC
    @(posedge clk_i);
    #1;
    set_port(0, 1'b1, 8'd10, 8'd20);
    push(0, 8'd30, 1'b0);
    req_i = 4'b0001;
    @(posedge clk_i);
    #1;
    set_port(0, 1'b0, 8'd1, 8'd200);
    req_i = 4'b0000;
    run(20, 1);
    // reset during CALC aborts and restarts arbitration at port 0
    set_port(2, 1'b1, 8'd3, 8'd4);
    req_i = 4'b0100;
    @(posedge clk_i);
    #1;
    chk("busy_calc", 32'(busy_o), 1);
    rst_i = 1'b0;
    req_i = 4'b0000;
    #1;
    chk("abort_ready", 32'(ready_o), 0);
    chk("abort_res", 32'(res_o), 0);
    chk("abort_carry", 32'(carry_o), 0);
    chk("abort_busy", 32'(busy_o), 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    set_port(0, 1'b1, 8'd7, 8'd8);
    set_port(3, 1'b0, 8'd7, 8'd7);
    push(0, 8'd15, 1'b0);
    push(3, 8'd0, 1'b0);
    req_i = 4'b1001;
    run(30, 1);
    repeat (4) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
